gf163_ds_mul: RTL and testbench



---
 rtl/gf163_ds_mul.sv | 169 ++++++++++++++++
 tb/tb_gf163_ds_mul.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf163_ds_mul.sv
// gf163_ds_mul -- digit-serial GF(2^163) multiplier, f(x) = x^163 + x^7 + x^6 + x^3 + 1.
//
// Consumes DIGIT bits of B per cycle, MSB-first (Horner form):
//   ACC <- ACC*x^DIGIT + A*b_d  (mod f)
// Start-to-done latency is ITER+1 cycles, where ITER = ceil(163/DIGIT).
//
// Optional feature: define GF_MUL_SQR_EN to build a single-cycle squaring path.
// A start with sqr=1 then computes op_a^2 mod f, with a latency of 2 cycles.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous, active-low reset
//   start   one-cycle request, sampled only while idle
//   sqr     squaring request (used only with GF_MUL_SQR_EN)
//   op_a    operand A (163 bits)
//   op_b    operand B (163 bits), ignored for squaring
//   busy    operation in progress
//   done    one-cycle pulse when result becomes valid
//   result  product, held from done until the next accepted start
module gf163_ds_mul #(
    parameter int DIGIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sqr,
    input  logic [162:0] op_a,
    input  logic [162:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [162:0] result
);
    localparam int ITER = (163 + DIGIT - 1) / DIGIT;
    localparam int BW   = ITER * DIGIT;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
`ifdef GF_MUL_SQR_EN
        , SQ
`endif
    } state_t;

    state_t state, state_next;

    logic [162:0]  a_reg;
    logic [BW-1:0] b_reg;
    logic [162:0]  acc;
    logic [CW-1:0] cnt;
    logic [162:0]  acc_next;
    logic [DIGIT-1:0] chunk;

    // Folds every bit at or above position 163 back down, starting from the
    // top bit. Bits produced by one fold may themselves sit at or above 163;
    // because the scan runs downwards, those bits are folded again later in
    // the same scan. This handles widths up to the 325 bits of a square.
    function automatic logic [162:0] gf_reduce(input logic [324:0] v);
        logic [324:0] t;
        int unsigned  i;
        t = v;
        for (int unsigned k = 0; k < 162; k++) begin
            i = 324 - k;
            if (t[i]) begin
                t[i]           = 1'b0;
                t[i-163 +: 8] ^= 8'b1100_1001;
            end
        end
        return t[162:0];
    endfunction

    assign chunk = b_reg[BW-1 -: DIGIT];

    // Reduction is linear, so the shifted ACC and the partial product A*b_d
    // are XORed first and then reduced once.
    always_comb begin
        logic [324:0] wide;
        wide = '0;
        wide[162+DIGIT:DIGIT] = acc;
        for (int unsigned j = 0; j < DIGIT; j++) begin
            if (chunk[j]) wide ^= 325'(a_reg) << j;
        end
        acc_next = gf_reduce(wide);
    end

`ifdef GF_MUL_SQR_EN
    logic [162:0] sq_next;
    always_comb begin
        logic [324:0] spread;
        spread = '0;
        for (int unsigned i = 0; i < 163; i++) spread[2*i] = a_reg[i];
        sq_next = gf_reduce(spread);
    end
`else
    logic sqr_unused;
    assign sqr_unused = sqr;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef GF_MUL_SQR_EN
                    state_next = sqr ? SQ : RUN;
`else
                    state_next = RUN;
`endif
                end
            end
            RUN:  if (cnt == CW'(ITER - 1)) state_next = DONE;
`ifdef GF_MUL_SQR_EN
            SQ:   state_next = DONE;
`endif
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef GF_MUL_SQR_EN
    assign busy = (state == RUN) || (state == SQ);
`else
    assign busy = (state == RUN);
`endif

    // done is registered: it is raised on the edge that leaves DONE,
    // together with the result update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= op_a;
                        b_reg <= BW'(op_b);
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    b_reg <= b_reg << DIGIT;
                    cnt   <= cnt + CW'(1);
                end
`ifdef GF_MUL_SQR_EN
                SQ: acc <= sq_next;
`endif
                DONE: begin
                    result <= acc;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gf163_ds_mul.sv
module tb_gf163_ds_mul;
    localparam int DIGIT = 4;
    localparam int ITER  = (163 + DIGIT - 1) / DIGIT;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sqr = 1'b0;
    logic [162:0] op_a = '0;
    logic [162:0] op_b = '0;
    logic         busy;
    logic         done;
    logic [162:0] result;

    int total = 0;
    int bad   = 0;
    logic [162:0] sb_q[$];

    gf163_ds_mul #(.DIGIT(DIGIT)) dut (
        .clk(clk), .rst(rst), .start(start), .sqr(sqr),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Bit-serial MSB-first reference: shift, reduce one bit, add A.
    function automatic logic [162:0] ref_mul(input logic [162:0] a, input logic [162:0] b);
        logic [163:0] r;
        r = '0;
        for (int i = 162; i >= 0; i--) begin
            r = r << 1;
            if (r[163]) r = r ^ {1'b1, 155'b0, 8'hC9};
            if (b[i]) r[162:0] = r[162:0] ^ a;
        end
        return r[162:0];
    endfunction

    function automatic logic [162:0] bit_at(input int n);
        logic [162:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic logic [162:0] rand163();
        logic [162:0] v;
        for (int i = 0; i < 6; i++) v[i*32 +: 32] = $urandom;
        v[162:160] = 3'($urandom);
        return v;
    endfunction

    // Drives a start in the current cycle; returns #1 after the accepting edge.
    task automatic start_op(input logic [162:0] a, input logic [162:0] b,
                            input logic s, input logic [162:0] expv);
        @(negedge clk);
        op_a = a; op_b = b; sqr = s; start = 1'b1;
        sb_q.push_back(expv);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a = rand163(); op_b = rand163();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy: busy=%b required=1", busy);
        end
    endtask

    // Waits for done, checks latency from the accepting edge, pops the scoreboard.
    task automatic wait_done(input string name, input int exp_lat, input int elapsed);
        int n;
        n = elapsed;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) break;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: no done after %0d cycles, required latency %0d", name, n, exp_lat);
            void'(sb_q.pop_front());
            return;
        end
        if (n != exp_lat) begin
            bad++;
            $display("FAIL %s_latency: got %0d required %0d", name, n, exp_lat);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_at_done: busy=%b required=0", name, busy);
        end
        total++;
        begin
            logic [162:0] expv;
            expv = sb_q.pop_front();
            if (result !== expv) begin
                bad++;
                $display("FAIL %s_result: got %h required %h", name, result, expv);
            end
        end
    endtask

    task automatic no_done_for(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL %s_extra_done: got %0d done pulses required 0", name, seen);
        end
    endtask

    task automatic test_reset();
        #2;
        total += 3;
        if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (done !== 1'b0)   begin bad++; $display("FAIL reset_done: got %b required 0", done); end
        if (result !== '0)   begin bad++; $display("FAIL reset_result: got %h required 0", result); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        logic [162:0] held;
        start_op(163'd1, 163'd1, 1'b0, 163'd1);
        wait_done("identity", ITER + 1, 0);
        held = result;
        @(posedge clk);
        #1;
        total += 2;
        if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width: done=%b required 0", done); end
        if (result !== held) begin bad++; $display("FAIL result_hold: got %h required %h", result, held); end
    endtask

    task automatic test_reduction();
        start_op(bit_at(162), 163'h2, 1'b0, 163'hC9);
        wait_done("reduction", ITER + 1, 0);
        start_op(163'd0, rand163(), 1'b0, '0);
        wait_done("zero_a", ITER + 1, 0);
    endtask

    task automatic test_ignore();
        logic [162:0] a, b;
        a = rand163(); b = rand163();
        start_op(a, b, 1'b0, ref_mul(a, b));
        repeat (9) @(posedge clk);
        @(negedge clk);
        op_a = rand163(); op_b = rand163(); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore", ITER + 1, 10);
        no_done_for("ignore", 60);
    endtask

    task automatic test_sqr();
`ifdef GF_MUL_SQR_EN
        start_op(163'h2, rand163(), 1'b1, 163'h4);
        wait_done("sqr_x", 2, 0);
        start_op(bit_at(100), rand163(), 1'b1,
                 bit_at(44) ^ bit_at(43) ^ bit_at(40) ^ bit_at(37));
        wait_done("sqr_x100", 2, 0);
        for (int i = 0; i < 4; i++) begin
            logic [162:0] a;
            a = rand163();
            start_op(a, rand163(), 1'b1, ref_mul(a, a));
            wait_done("sqr_rand", 2, 0);
        end
`else
        start_op(163'h2, 163'd1, 1'b1, 163'h2);
        wait_done("sqr_off_x", ITER + 1, 0);
        start_op(bit_at(100), 163'd1, 1'b1, bit_at(100));
        wait_done("sqr_off_x100", ITER + 1, 0);
`endif
    endtask

    task automatic test_reset_mid_op();
        logic [162:0] a, b;
        a = rand163(); b = rand163();
        start_op(a, b, 1'b0, ref_mul(a, b));
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        total += 3;
        if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b required 0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL midreset_done: got %b required 0", done); end
        if (result !== '0) begin bad++; $display("FAIL midreset_result: got %h required 0", result); end
        void'(sb_q.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        no_done_for("midreset", 60);
        a = rand163(); b = rand163();
        start_op(a, b, 1'b0, ref_mul(a, b));
        wait_done("after_reset", ITER + 1, 0);
    endtask

    // Each new start is issued in the cycle done is high (one op per ITER+2).
    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            logic [162:0] a, b;
            a = rand163(); b = rand163();
            if (i == 0) b = '1;
            if (i == 1) a = '1;
            start_op(a, b, 1'b0, ref_mul(a, b));
            wait_done("random", ITER + 1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_reduction();
        test_ignore();
        test_sqr();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
